// File: rtl/axis_frame_gen_if.sv
// axis_frame_gen_if: AXI-stream bundle between the frame generator and its sink
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;
  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: emits runs of counting-pattern AXI-stream frames with gaps, error marking and abort
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [7:0]            cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [CNT_WIDTH-1:0]  cfg_bad_period,
  axis_frame_gen_if.master      m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_n;
  logic [LEN_WIDTH-1:0]  len_r, len_a, beat, nb;
  logic [CNT_WIDTH-1:0]  cnt_r, bad_r, bad_a, bad_ctr, nbc, fs_inc;
  logic [DATA_WIDTH-1:0] seed_r, seed_a;
  logic [7:0]            gap_r, gap_cnt;
  logic                  idle, hs, last_hs, last_n, user_n;
  assign m_axis.tkeep = '1;
  // In IDLE the live cfg inputs stand in for the latched copies so the first beat is ready on the start edge
  always_comb begin
    idle    = state == IDLE;
    len_a   = idle ? (cfg_len == '0 ? LEN_WIDTH'(1) : cfg_len) : len_r;
    seed_a  = idle ? cfg_seed : seed_r;
    bad_a   = idle ? cfg_bad_period : bad_r;
    hs      = state == SEND && m_axis.tready;
    last_hs = hs && m_axis.tlast;
    fs_inc  = frames_sent + CNT_WIDTH'(1);
    state_n = state;
    unique case (state)
      IDLE:    state_n = !start ? IDLE : cfg_count != '0 ? SEND : DONE;
      SEND:    state_n = !last_hs ? SEND : (fs_inc == cnt_r || abort) ? DONE : gap_r == '0 ? SEND : GAP;
      GAP:     state_n = abort ? DONE : gap_cnt == 8'd1 ? SEND : GAP;
      default: state_n = IDLE;
    endcase
    nb      = (state != SEND || last_hs) ? '0 : beat + LEN_WIDTH'(hs);
    nbc     = idle ? '0 : !last_hs ? bad_ctr : bad_ctr == bad_r - CNT_WIDTH'(1) ? '0 : bad_ctr + CNT_WIDTH'(1);
    last_n  = nb == len_a - LEN_WIDTH'(1);
    user_n  = last_n && bad_a != '0 && nbc == bad_a - CNT_WIDTH'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r         <= '0;
      cnt_r         <= '0;
      gap_r         <= '0;
      seed_r        <= '0;
      bad_r         <= '0;
      beat          <= '0;
      bad_ctr       <= '0;
      gap_cnt       <= '0;
      frames_sent   <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (idle && start) begin
        len_r       <= len_a;
        cnt_r       <= cfg_count;
        gap_r       <= cfg_gap;
        seed_r      <= cfg_seed;
        bad_r       <= cfg_bad_period;
        frames_sent <= '0;
      end else if (last_hs) begin
        frames_sent <= fs_inc;
      end
      beat          <= nb;
      bad_ctr       <= nbc;
      gap_cnt       <= state == GAP ? gap_cnt - 8'd1 : gap_r;
      m_axis.tvalid <= state_n == SEND;
      m_axis.tlast  <= state_n == SEND && last_n;
      m_axis.tuser  <= state_n == SEND && user_n;
      if (state_n == SEND) m_axis.tdata <= seed_a + DATA_WIDTH'(nb);
      busy          <= state_n != IDLE;
      done          <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: randomized runs of axis_frame_gen checked against a frame-list reference model
module tb_axis_frame_gen;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int CW = 16;
  localparam int MASK = (1 << DW) - 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [7:0]    cfg_gap = '0;
  logic [DW-1:0] cfg_seed = '0;
  logic [CW-1:0] cfg_bad_period = '0;
  logic          busy, done;
  logic [CW-1:0] frames_sent;
  int errors = 0;
  int checks = 0;
  axis_frame_gen_if #(.DATA_WIDTH(DW)) m_axis ();
  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
    .cfg_bad_period(cfg_bad_period), .m_axis(m_axis),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || m_axis.tuser !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v%b l%b u%b want 000", m_axis.tvalid, m_axis.tlast, m_axis.tuser);
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b want 0 0", busy, done);
    end
    if (frames_sent !== '0 || m_axis.tdata !== '0) begin
      errors++; $display("FAIL reset_data: got frames=%0d tdata=%0h want 0 0", frames_sent, m_axis.tdata);
    end
    if (m_axis.tkeep !== 1'b1) begin
      errors++; $display("FAIL reset_tkeep: got %b want 1", m_axis.tkeep);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // rmode: 0 tready always 1, 1 toggling 1010..., 2 random; ab: raise abort once ab beats have handshaken (0 = never)
  task automatic run_frames(input string name, input int len, input int count, input int gap,
                            input int seed, input int bad, input int rmode, input int ab);
    int exp_q[$];
    int got_q[$];
    int gaps_q[$];
    int le = (len == 0) ? 1 : len;
    int nf = count;
    bit gap_abort = ab > 0 && ab % le == 0 && gap != 0 && ab / le < count;
    int exp_since;
    int exp_gaps;
    int since = 0;
    int run = 0;
    int obs, pobs = 0;
    bit pstall = 0;
    bit fin = 0;
    bit ready;
    if (ab > 0) begin
      int fa = (ab % le == 0 && gap != 0) ? ab / le : ab / le + 1;
      if (fa < nf) nf = fa;
    end
    exp_since = gap_abort ? 2 : 1;
    exp_gaps = (gap == 0 || nf < 2) ? 0 : nf - 1;
    for (int f = 1; f <= nf; f++)
      for (int k = 0; k < le; k++) begin
        int lst = (k == le - 1) ? 1 : 0;
        int usr = (lst == 1 && bad != 0 && f % bad == 0) ? 1 : 0;
        exp_q.push_back((((seed + k) & MASK) << 2) | (lst << 1) | usr);
      end
    @(negedge clk);
    cfg_len = LW'(len);
    cfg_count = CW'(count);
    cfg_gap = 8'(gap);
    cfg_seed = DW'(seed);
    cfg_bad_period = CW'(bad);
    abort = 1'b0;
    start = 1'b1;
    m_axis.tready = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        cfg_len = LW'($urandom);
        cfg_count = CW'($urandom);
        cfg_gap = 8'($urandom);
        cfg_seed = DW'($urandom);
        cfg_bad_period = CW'($urandom);
      end
      since++;
      if (ab > 0 && got_q.size() >= ab) abort = 1'b1;
      ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      m_axis.tready = ready;
      obs = int'({m_axis.tdata, m_axis.tlast, m_axis.tuser});
      if (pstall) begin
        checks++;
        if (m_axis.tvalid !== 1'b1 || obs !== pobs) begin
          errors++; $display("FAIL %s stall_hold: got v%b beat %0h want v1 beat %0h", name, m_axis.tvalid, obs, pobs);
        end
      end
      if (done === 1'b1) begin
        fin = 1;
        start = 1'b0;
        checks += 3;
        if (since !== exp_since) begin
          errors++; $display("FAIL %s done_latency: got %0d want %0d", name, since, exp_since);
        end
        if (m_axis.tvalid !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL %s done_outputs: got tvalid=%b busy=%b want 0 1", name, m_axis.tvalid, busy);
        end
        if (frames_sent !== CW'(nf)) begin
          errors++; $display("FAIL %s frames_sent: got %0d want %0d", name, frames_sent, nf);
        end
      end else begin
        if (m_axis.tvalid === 1'b1) begin
          if (run > 0) gaps_q.push_back(run);
          run = 0;
          if (ready) begin
            got_q.push_back(obs);
            since = 0;
          end
        end else if (got_q.size() > 0) begin
          run++;
        end
        start = 1'($urandom_range(0, 3) == 0);
      end
      pstall = m_axis.tvalid === 1'b1 && !ready;
      pobs = obs;
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout: got no done want done", name);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || m_axis.tvalid !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b tvalid=%b want 0 0 0", name, done, busy, m_axis.tvalid);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s beat_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s beat%0d {tdata,tlast,tuser}: got %0h want %0h", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (gaps_q.size() != exp_gaps) begin
      errors++; $display("FAIL %s gap_count: got %0d want %0d", name, gaps_q.size(), exp_gaps);
    end
    foreach (gaps_q[i]) begin
      checks++;
      if (gaps_q[i] !== gap) begin
        errors++; $display("FAIL %s gap%0d_len: got %0d want %0d", name, i, gaps_q[i], gap);
      end
    end
  endtask

  task automatic test_back_to_back;  run_frames("b2b_wrap", 4, 2, 0, 'hFE, 0, 0, 0); endtask
  task automatic test_stall;         run_frames("stall", 3, 1, 0, 'h10, 0, 1, 0); endtask
  task automatic test_gap_bad;       run_frames("gap_bad", 2, 4, 3, 'h30, 2, 0, 0); endtask
  task automatic test_zero_count;    run_frames("zero_count", 4, 0, 2, 'h55, 1, 0, 0); endtask
  task automatic test_abort_send;    run_frames("abort_send", 4, 10, 0, 'h01, 0, 2, 5); endtask
  task automatic test_abort_gap;     run_frames("abort_gap", 3, 5, 2, 'h80, 0, 2, 3); endtask
  task automatic test_len_one;
    run_frames("len1", 1, 3, 0, 'hFF, 1, 2, 0);
    run_frames("len0", 0, 2, 1, 'h7F, 2, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      run_frames($sformatf("rand%0d", i), $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4),
                 $urandom_range(0, MASK), $urandom_range(0, 3), 2,
                 $urandom_range(0, 1) == 1 ? $urandom_range(1, 20) : 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cfg_len = 8;
    cfg_count = 3;
    cfg_gap = 0;
    cfg_seed = 'h20;
    cfg_bad_period = 0;
    start = 1'b1;
    m_axis.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    checks++;
    if (m_axis.tvalid !== 1'b0 || busy !== 1'b0 || frames_sent !== '0 || m_axis.tdata !== '0) begin
      errors++; $display("FAIL reset_mid_async: got tvalid=%b busy=%b frames=%0d tdata=%0h want 0 0 0 0",
                         m_axis.tvalid, busy, frames_sent, m_axis.tdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (m_axis.tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: got tvalid=%b busy=%b want 0 0", m_axis.tvalid, busy);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (m_axis.tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_stays_idle: got tvalid=%b busy=%b done=%b want 0 0 0", m_axis.tvalid, busy, done);
    end
  endtask

  initial begin
    m_axis.tready = 1'b0;
    test_reset;
    test_back_to_back;
    test_stall;
    test_gap_bad;
    test_zero_count;
    test_abort_send;
    test_abort_gap;
    test_len_one;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
